// File: rtl/legv8_pkg.sv
// ============================================================================
// Module   : legv8_pkg
// Purpose  : Shared widths, indices and types for the LEGv8 writeback path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package legv8_pkg;

  localparam int DATA_W        = 64;
  localparam int REG_IDX_W     = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_ENTRY_W    = REG_IDX_W + DATA_W;

  localparam logic [REG_IDX_W-1:0] XZR_IDX = 5'd31;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic [REG_IDX_W-1:0] wr;
    logic [DATA_W-1:0]    wd;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/legv8_wb_fifo.sv
// ============================================================================
// Module   : legv8_wb_fifo
// Purpose  : Small registered FIFO holding pending writeback entries.
// Revision : 1.0
// ============================================================================
`default_nettype none

module legv8_wb_fifo
  import legv8_pkg::*;
#(
  parameter int WIDTH = WB_ENTRY_W,
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Flags come from the registered count only, so an entry pushed this
  // cycle is not visible to the reader until the next one.
  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/legv8_wb_arbiter.sv
// ============================================================================
// Module   : legv8_wb_arbiter
// Purpose  : Round-robin merge of ALU and load writebacks into one RF port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module legv8_wb_arbiter
  import legv8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_wr,
  input  logic [DATA_W-1:0]    alu_wd,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_wr,
  input  logic [DATA_W-1:0]    mem_wd,
  output logic                 mem_ready,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] WR,
  output logic [DATA_W-1:0]    WD,
  output logic                 idle
);

  logic      w_alu_full;
  logic      w_alu_empty;
  logic      w_mem_full;
  logic      w_mem_empty;
  wb_entry_t w_alu_head;
  wb_entry_t w_mem_head;
  wb_entry_t w_alu_din;
  wb_entry_t w_mem_din;
  wb_entry_t w_sel;
  logic      w_alu_push;
  logic      w_mem_push;
  logic      w_alu_pop;
  logic      w_mem_pop;
  logic      w_gnt_valid;
  req_e      w_gnt;
  req_e      r_last_gnt;

  // Ready is forced low while reset is held, independent of FIFO state.
  assign alu_ready  = rst && !w_alu_full;
  assign mem_ready  = rst && !w_mem_full;
  assign w_alu_push = alu_valid && alu_ready;
  assign w_mem_push = mem_valid && mem_ready;
  assign w_alu_din  = '{wr: alu_wr, wd: alu_wd};
  assign w_mem_din  = '{wr: mem_wr, wd: mem_wd};

  legv8_wb_fifo #(.WIDTH(WB_ENTRY_W), .DEPTH(WB_FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_alu_push),
    .pop   (w_alu_pop),
    .din   (w_alu_din),
    .full  (w_alu_full),
    .empty (w_alu_empty),
    .head  (w_alu_head)
  );

  legv8_wb_fifo #(.WIDTH(WB_ENTRY_W), .DEPTH(WB_FIFO_DEPTH)) u_mem_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_mem_push),
    .pop   (w_mem_pop),
    .din   (w_mem_din),
    .full  (w_mem_full),
    .empty (w_mem_empty),
    .head  (w_mem_head)
  );

  assign w_gnt_valid = !w_alu_empty || !w_mem_empty;

  always_comb begin
    w_gnt = REQ_ALU;
    if (w_alu_empty) begin
      w_gnt = REQ_MEM;
    end else if (w_mem_empty) begin
      w_gnt = REQ_ALU;
    end else begin
      w_gnt = (r_last_gnt == REQ_MEM) ? REQ_ALU : REQ_MEM;
    end
  end

  assign w_alu_pop = w_gnt_valid && (w_gnt == REQ_ALU);
  assign w_mem_pop = w_gnt_valid && (w_gnt == REQ_MEM);
  assign w_sel     = (w_gnt == REQ_ALU) ? w_alu_head : w_mem_head;

  // XZR entries are drained like any other but never raise the write enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWrite   <= 1'b0;
      WR         <= '0;
      WD         <= '0;
      r_last_gnt <= REQ_MEM;
    end else begin
      RegWrite <= w_gnt_valid && (w_sel.wr != XZR_IDX);
      if (w_gnt_valid) begin
        r_last_gnt <= w_gnt;
        WR         <= w_sel.wr;
        WD         <= w_sel.wd;
      end
    end
  end

  assign idle = w_alu_empty && w_mem_empty && !RegWrite;

endmodule

`default_nettype wire

// File: tb/tb_legv8_wb_arbiter.sv
// ============================================================================
// Module   : tb_legv8_wb_arbiter
// Purpose  : Directed self-checking bench for the writeback arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_legv8_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_wr;
  logic [63:0] alu_wd;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_wr;
  logic [63:0] mem_wd;
  logic        mem_ready;
  logic        RegWrite;
  logic [4:0]  WR;
  logic [63:0] WD;
  logic        idle;

  int n_total;
  int n_bad;

  legv8_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_wr    (alu_wr),
    .alu_wd    (alu_wd),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_wr    (mem_wr),
    .mem_wd    (mem_wd),
    .mem_ready (mem_ready),
    .RegWrite  (RegWrite),
    .WR        (WR),
    .WD        (WD),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ai;
    int mi;
    int k;
    logic acc_a;
    logic acc_m;
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b0;
    alu_valid = 1'b0;
    alu_wr    = '0;
    alu_wd    = '0;
    mem_valid = 1'b0;
    mem_wr    = '0;
    mem_wd    = '0;

    // Reset state
    #2;
    check("rst_rw", RegWrite, 0);
    check("rst_wr", WR, 0);
    check("rst_wd", WD, 0);
    check("rst_idle", idle, 1);
    check("rst_ardy", alu_ready, 0);
    check("rst_mrdy", mem_ready, 0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rel_ardy", alu_ready, 1);
    check("rel_mrdy", mem_ready, 1);

    // Simultaneous push after reset: ALU wins first contention
    alu_valid = 1; alu_wr = 5'd1; alu_wd = 64'h11;
    mem_valid = 1; mem_wr = 5'd2; mem_wd = 64'h22;
    step();
    alu_valid = 0; mem_valid = 0;
    check("dual_rw0", RegWrite, 0);
    step();
    check("dual_rw1", RegWrite, 1);
    check("dual_wr1", WR, 1);
    check("dual_wd1", WD, 64'h11);
    step();
    check("dual_rw2", RegWrite, 1);
    check("dual_wr2", WR, 2);
    check("dual_wd2", WD, 64'h22);
    step();
    check("dual_rw3", RegWrite, 0);
    check("dual_idle", idle, 1);

    // Single ALU push: write visible for exactly one cycle, one cycle later
    alu_valid = 1; alu_wr = 5'd5; alu_wd = 64'hDEAD;
    step();
    alu_valid = 0;
    check("one_rw0", RegWrite, 0);
    check("one_idle0", idle, 0);
    step();
    check("one_rw1", RegWrite, 1);
    check("one_wr1", WR, 5);
    check("one_wd1", WD, 64'hDEAD);
    step();
    check("one_rw2", RegWrite, 0);
    check("one_idle2", idle, 1);

    // Backpressure: ALU loses to MEM, fills, third request held
    alu_valid = 1; alu_wr = 5'd6; alu_wd = 64'hA0;
    mem_valid = 1; mem_wr = 5'd7; mem_wd = 64'hB0;
    step();
    check("bp_rdy0", alu_ready, 1);
    check("bp_rw0", RegWrite, 0);
    alu_wd = 64'hA1; mem_wd = 64'hB1;
    step();
    check("bp_rdy1", alu_ready, 0);
    check("bp_wr1", WR, 7);
    check("bp_wd1", WD, 64'hB0);
    alu_wd = 64'hA2; mem_valid = 0;
    step();
    check("bp_rdy2", alu_ready, 1);
    check("bp_wr2", WR, 6);
    check("bp_wd2", WD, 64'hA0);
    step();
    alu_valid = 0;
    check("bp_rdy3", alu_ready, 0);
    check("bp_wd3", WD, 64'hB1);
    step();
    check("bp_wd4", WD, 64'hA1);
    step();
    check("bp_rw5", RegWrite, 1);
    check("bp_wd5", WD, 64'hA2);
    step();
    check("bp_rw6", RegWrite, 0);
    check("bp_idle6", idle, 1);

    // XZR destination is consumed silently
    alu_valid = 1; alu_wr = 5'd31; alu_wd = 64'h1234;
    step();
    alu_valid = 0;
    check("xzr_idle0", idle, 0);
    step();
    check("xzr_rw1", RegWrite, 0);
    check("xzr_idle1", idle, 1);
    step();
    check("xzr_rw2", RegWrite, 0);

    // Loaded FIFOs, short reset pulse between clock edges
    alu_valid = 1; alu_wr = 5'd3; alu_wd = 64'hC0;
    mem_valid = 1; mem_wr = 5'd4; mem_wd = 64'hD0;
    step();
    step();
    step();
    check("ar_rw_pre", RegWrite, 1);
    #2;
    rst = 1'b0;
    #1;
    alu_valid = 0; mem_valid = 0;
    check("ar_rw", RegWrite, 0);
    check("ar_wr", WR, 0);
    check("ar_wd", WD, 0);
    check("ar_idle", idle, 1);
    check("ar_ardy", alu_ready, 0);
    check("ar_mrdy", mem_ready, 0);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("ar_post_rw", RegWrite, 0);
      check("ar_post_idle", idle, 1);
      check("ar_post_ardy", alu_ready, 1);
      check("ar_post_mrdy", mem_ready, 1);
    end

    // Continuous load: strict ALU/MEM alternation, per-requester order
    ai = 0;
    mi = 0;
    alu_valid = 1; alu_wr = 5'd8; alu_wd = 64'hA000;
    mem_valid = 1; mem_wr = 5'd9; mem_wd = 64'hB000;
    for (int c = 0; c <= 20; c++) begin
      acc_a = alu_valid && alu_ready;
      acc_m = mem_valid && mem_ready;
      step();
      if (acc_a) ai = ai + 1;
      if (acc_m) mi = mi + 1;
      alu_wd = 64'hA000 + 64'(ai);
      mem_wd = 64'hB000 + 64'(mi);
      if (c >= 1) begin
        k = c - 1;
        check("st_rw", RegWrite, 1);
        check("st_wr", WR, (k % 2 == 0) ? 64'd8 : 64'd9);
        check("st_wd", WD, ((k % 2 == 0) ? 64'hA000 : 64'hB000) + 64'(k / 2));
      end
    end
    alu_valid = 0;
    mem_valid = 0;
    for (int c = 0; c < 10 && !idle; c++) begin
      step();
    end
    check("st_drain_idle", idle, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
